// File: rtl/y_rx_pkg.sv
// Shared types and constants for the Y-bus receiver.
package y_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACK      = 2'd1,
    ST_WAIT_LOW = 2'd2
  } rx_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int unsigned ERRW_DEFAULT = 8;

  // A word is good when data XOR parity reduces to the selected mode bit.
  function automatic logic parity_ok(input logic [31:0] data,
                                     input logic        par,
                                     input logic        mode);
    return ((^data) ^ par) == (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/y_rx_fifo.sv
// Power-of-two circular FIFO; head word is held on DOUT after the FIFO drains.
module y_rx_fifo
  import y_rx_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned DW    = 32,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] last_q;
  logic          push_eff, pop_eff;

  assign pop_eff  = pop && (count_q != '0);
  assign push_eff = push && (count_q != FULL);

  always_comb begin
    count_d = count_q;
    if (push_eff && !pop_eff)
      count_d = count_q + CW'(1);
    else if (!push_eff && pop_eff)
      count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push_eff)
      mem_q[wr_ptr_q] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (push_eff)
        wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_eff)
        rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (count_q != '0)
        last_q <= mem_q[rd_ptr_q];
    end
  end

  // Storage is not reset, so the head is only exposed while non-empty.
  assign dout  = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;
  assign count = count_q;

endmodule

// File: rtl/y_receiver.sv
// Four-phase Y-bus receiver: parity-checks each word, queues good ones, counts bad ones.
module y_receiver
  import y_rx_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned ERRW  = ERRW_DEFAULT,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic            YREQ,
  input  logic [31:0]     YDATA,
  input  logic            YPARITY,
  input  logic            PARTYSEL,
  output logic            YACK,
  output logic [31:0]     DOUT,
  output logic            DVALID,
  input  logic            DREADY,
  output logic            PERR,
  output logic [ERRW-1:0] ERRCNT,
  output logic [CW-1:0]   COUNT
);

  rx_state_e       state_q;
  logic            yack_q;
  logic            perr_q;
  logic [ERRW-1:0] errcnt_q;
  logic [CW-1:0]   fifo_count;
  logic            word_good;
  logic            has_space;
  logic            accept;
  logic            push;

  assign word_good = parity_ok(YDATA, YPARITY, PARTYSEL);
  assign has_space = fifo_count < CW'(DEPTH);
  // Bad words are never stored, so they are accepted even when full.
  assign accept    = (state_q == ST_IDLE) && YREQ && (has_space || !word_good);
  assign push      = accept && word_good;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= ST_IDLE;
      yack_q   <= 1'b0;
      perr_q   <= 1'b0;
      errcnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_ACK;
            yack_q  <= 1'b1;
            if (!word_good) begin
              perr_q <= 1'b1;
              if (errcnt_q != '1)
                errcnt_q <= errcnt_q + ERRW'(1);
            end
          end
        end
        ST_ACK: begin
          if (!YREQ) begin
            state_q <= ST_WAIT_LOW;
            yack_q  <= 1'b0;
          end
        end
        ST_WAIT_LOW: begin
          state_q <= ST_IDLE;
          yack_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          yack_q  <= 1'b0;
        end
      endcase
    end
  end

  y_rx_fifo #(
    .DEPTH (DEPTH),
    .DW    (32)
  ) u_fifo (
    .clk   (HCLK),
    .rst   (HRESET),
    .push  (push),
    .pop   (DREADY),
    .din   (YDATA),
    .dout  (DOUT),
    .count (fifo_count)
  );

  assign YACK   = yack_q;
  assign PERR   = perr_q;
  assign ERRCNT = errcnt_q;
  assign COUNT  = fifo_count;
  assign DVALID = (fifo_count != '0);

endmodule

// File: tb/tb_y_receiver.sv
// Directed and randomized bench for y_receiver against a queue-based reference model.
module tb_y_receiver;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned ERRW    = 8;
  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam int          ERR_MAX = (1 << ERRW) - 1;

  logic            HCLK;
  logic            HRESET;
  logic            YREQ;
  logic [31:0]     YDATA;
  logic            YPARITY;
  logic            PARTYSEL;
  logic            YACK;
  logic [31:0]     DOUT;
  logic            DVALID;
  logic            DREADY;
  logic            PERR;
  logic [ERRW-1:0] ERRCNT;
  logic [CW-1:0]   COUNT;

  y_receiver #(
    .DEPTH (DEPTH),
    .ERRW  (ERRW)
  ) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .YREQ     (YREQ),
    .YDATA    (YDATA),
    .YPARITY  (YPARITY),
    .PARTYSEL (PARTYSEL),
    .YACK     (YACK),
    .DOUT     (DOUT),
    .DVALID   (DVALID),
    .DREADY   (DREADY),
    .PERR     (PERR),
    .ERRCNT   (ERRCNT),
    .COUNT    (COUNT)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  // Reference model: stored words, last shown head, error totals, handshake phase.
  logic [31:0] m_q[$];
  logic [31:0] m_last;
  int          m_err;
  bit          m_perr;
  int          m_phase; // 0 waiting for request, 1 acknowledged, 2 one-cycle gap

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A word is good when its total count of ones (data plus parity bit) matches the mode.
  function automatic bit good_word(input logic [31:0] d, input logic p, input logic sel);
    int ones;
    ones = $countones(d) + int'(p);
    return (ones % 2) == int'(sel);
  endfunction

  function automatic logic pick_par(input logic [31:0] d, input logic sel, input bit bad);
    logic p;
    p = logic'($countones(d) % 2) ^ sel;
    return bad ? ~p : p;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_last  = '0;
    m_err   = 0;
    m_perr  = 1'b0;
    m_phase = 0;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_dout;
    exp_dout = (m_q.size() > 0) ? m_q[0] : m_last;
    chk({tag, ".count"},  32'(COUNT),  32'(m_q.size()));
    chk({tag, ".dvalid"}, 32'(DVALID), 32'(m_q.size() > 0));
    chk({tag, ".dout"},   DOUT,        exp_dout);
    chk({tag, ".yack"},   32'(YACK),   32'(m_phase == 1));
    chk({tag, ".perr"},   32'(PERR),   32'(m_perr));
    chk({tag, ".errcnt"}, 32'(ERRCNT), 32'(m_err));
  endtask

  // One clock: predict from the inputs presented, step, then compare on the falling edge.
  task automatic tick(input string tag);
    bit do_pop, do_acc, bad;
    do_pop = DREADY && (m_q.size() > 0);
    bad    = !good_word(YDATA, YPARITY, PARTYSEL);
    do_acc = (m_phase == 0) && YREQ && ((m_q.size() < DEPTH) || bad);
    @(posedge HCLK);
    if (do_pop) void'(m_q.pop_front());
    if (do_acc) begin
      if (bad) begin
        m_perr = 1'b1;
        if (m_err < ERR_MAX) m_err++;
      end else begin
        m_q.push_back(YDATA);
      end
      m_phase = 1;
    end else if (m_phase == 1 && !YREQ) begin
      m_phase = 2;
    end else if (m_phase == 2) begin
      m_phase = 0;
    end
    if (m_q.size() > 0) m_last = m_q[0];
    @(negedge HCLK);
    check_all(tag);
  endtask

  task automatic handshake(input string tag, input logic [31:0] d, input logic p);
    YDATA   = d;
    YPARITY = p;
    YREQ    = 1'b1;
    for (int i = 0; i < 20 && m_phase != 1; i++) tick(tag);
    chk({tag, ".ack"}, 32'(YACK), 32'd1);
    YREQ = 1'b0;
    tick(tag);
    tick(tag);
  endtask

  task automatic drain();
    DREADY = 1'b1;
    repeat (DEPTH + 1) tick("drain");
    DREADY = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    bit          bad;

    HRESET   = 1'b1;
    YREQ     = 1'b0;
    YDATA    = '0;
    YPARITY  = 1'b0;
    PARTYSEL = 1'b0;
    DREADY   = 1'b0;
    model_reset();
    @(negedge HCLK);
    check_all("reset");
    HRESET = 1'b0;

    // Even mode good word 0x3.
    PARTYSEL = 1'b0;
    handshake("even_good", 32'h0000_0003, 1'b0);
    chk("even_good.count1", 32'(COUNT), 32'd1);
    chk("even_good.dout3",  DOUT,       32'h3);
    drain();

    // Odd mode bad word.
    PARTYSEL = 1'b1;
    handshake("odd_bad", 32'h0000_0001, 1'b1);
    chk("odd_bad.count0",  32'(COUNT),  32'd0);
    chk("odd_bad.perr",    32'(PERR),   32'd1);
    chk("odd_bad.errcnt1", 32'(ERRCNT), 32'd1);

    // Fill to full, then stall the fifth word until one pop.
    PARTYSEL = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      handshake("fill", d, pick_par(d, 1'b0, 1'b0));
    end
    chk("fill.count4", 32'(COUNT), 32'd4);
    d       = $urandom;
    YDATA   = d;
    YPARITY = pick_par(d, 1'b0, 1'b0);
    YREQ    = 1'b1;
    repeat (4) tick("stall");
    chk("stall.yack0", 32'(YACK), 32'd0);
    DREADY = 1'b1;
    tick("stall_pop");
    DREADY = 1'b0;
    for (int i = 0; i < 5 && m_phase != 1; i++) tick("stall_resume");
    chk("stall.acked", 32'(YACK), 32'd1);
    YREQ = 1'b0;
    tick("stall_end");
    tick("stall_end");
    chk("stall.count4", 32'(COUNT), 32'd4);
    drain();

    // Randomized words, modes and sink back-pressure.
    for (int w = 0; w < 60; w++) begin
      PARTYSEL = logic'($urandom_range(0, 1));
      bad      = ($urandom_range(0, 3) == 0);
      d        = $urandom;
      YDATA    = d;
      YPARITY  = pick_par(d, PARTYSEL, bad);
      YREQ     = 1'b1;
      for (int i = 0; i < 30 && m_phase != 1; i++) begin
        DREADY = logic'($urandom_range(0, 1));
        tick("rand");
      end
      chk("rand.ack", 32'(YACK), 32'd1);
      YREQ = 1'b0;
      for (int i = 0; i < 2; i++) begin
        DREADY = logic'($urandom_range(0, 1));
        tick("rand");
      end
    end
    DREADY = 1'b0;
    drain();

    // Error counter saturation.
    PARTYSEL = 1'b0;
    for (int i = 0; i < 300; i++) begin
      d = $urandom;
      handshake("sat", d, pick_par(d, 1'b0, 1'b1));
    end
    chk("sat.errcnt", 32'(ERRCNT), 32'(ERR_MAX));
    chk("sat.perr",   32'(PERR),   32'd1);

    // Reset asserted while acknowledging with two words queued.
    @(negedge HCLK);
    #1 HRESET = 1'b1;
    #1;
    chk("rst0.yack",  32'(YACK),  32'd0);
    chk("rst0.count", 32'(COUNT), 32'd0);
    @(negedge HCLK);
    model_reset();
    HRESET = 1'b0;
    check_all("rst0_release");
    d = $urandom;
    handshake("pre_rst", d, pick_par(d, 1'b0, 1'b0));
    d       = $urandom;
    YDATA   = d;
    YPARITY = pick_par(d, 1'b0, 1'b0);
    YREQ    = 1'b1;
    tick("pre_rst_ack");
    chk("pre_rst.count2", 32'(COUNT), 32'd2);
    chk("pre_rst.yack1",  32'(YACK),  32'd1);
    #1 HRESET = 1'b1;
    #1;
    chk("mid_rst.yack",   32'(YACK),   32'd0);
    chk("mid_rst.count",  32'(COUNT),  32'd0);
    chk("mid_rst.dvalid", 32'(DVALID), 32'd0);
    chk("mid_rst.dout",   DOUT,        32'd0);
    @(negedge HCLK);
    model_reset();
    HRESET = 1'b0;
    check_all("rst_release");
    for (int i = 0; i < 5 && m_phase != 1; i++) tick("reaccept");
    chk("reaccept.yack",  32'(YACK),  32'd1);
    chk("reaccept.count", 32'(COUNT), 32'd1);
    chk("reaccept.dout",  DOUT,       d);
    YREQ = 1'b0;
    tick("reaccept_end");
    tick("reaccept_end");
    drain();

    // Push and pop together at occupancy two, across pointer wrap.
    for (int i = 0; i < 2; i++) begin
      d = $urandom;
      handshake("pp_fill", d, pick_par(d, 1'b0, 1'b0));
    end
    for (int i = 0; i < 10; i++) begin
      d       = $urandom;
      YDATA   = d;
      YPARITY = pick_par(d, 1'b0, 1'b0);
      YREQ    = 1'b1;
      DREADY  = 1'b1;
      tick("pushpop");
      chk("pushpop.count2", 32'(COUNT), 32'd2);
      DREADY = 1'b0;
      YREQ   = 1'b0;
      tick("pushpop_end");
      tick("pushpop_end");
    end
    drain();
    chk("final.dvalid", 32'(DVALID), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/y_receiver.md
Y_RECEIVER -- requirements
Module: y_receiver

Interface
REQ-001 Parameter: DEPTH, 4, FIFO entries (power of two, 2..16).
REQ-002 Parameter: ERRW, 8, error-counter width.
REQ-003 Port: HCLK  input  1  single clock; all state updates on rising edge.
REQ-004 Port: HRESET  input  1  reset, asynchronous, active-high.
REQ-005 Port: YREQ  input  1  producer request; YDATA/YPARITY are stable while high.
REQ-006 Port: YDATA  input  32  data word from write buffer.
REQ-007 Port: YPARITY  input  1  parity bit accompanying YDATA.
REQ-008 Port: PARTYSEL  input  1  parity mode: 0 = even, 1 = odd.
REQ-009 Port: YACK  output  1  acknowledge to producer (registered).
REQ-010 Port: DOUT  output  32  FIFO head word.
REQ-011 Port: DVALID  output  1  FIFO non-empty.
REQ-012 Port: DREADY  input  1  sink pops head when DVALID and DREADY are both high.
REQ-013 Port: PERR  output  1  sticky parity-error flag.
REQ-014 Port: ERRCNT  output  ERRW  count of parity-failed words, saturating.
REQ-015 Port: COUNT  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 Handshake SHALL be four-phase: YREQ rises -> YACK rises -> YREQ falls -> YACK falls.
REQ-017 FSM states SHALL be IDLE, ACK and WAIT_LOW.
REQ-018 IDLE: if YREQ=1 and a word can be accepted, sample YDATA/YPARITY at that edge and go to ACK; YACK=1 from the next cycle (latency 1).
REQ-019 A word can be accepted when the registered COUNT < DEPTH or the word fails parity.
REQ-020 IDLE with YREQ=1 and FIFO full with good parity: hold YACK=0 and stay in IDLE until space frees (stall).
REQ-021 ACK: YACK=1; when YREQ=0 go to WAIT_LOW.
REQ-022 WAIT_LOW: YACK=0 for exactly one cycle, then IDLE; a YREQ seen in WAIT_LOW is not sampled.
REQ-023 Parity check, even mode: word is good iff (^YDATA)^YPARITY = 0.
REQ-024 Parity check, odd mode: word is good iff (^YDATA)^YPARITY = 1.
REQ-025 Good words SHALL be pushed into the FIFO at the sample edge.
REQ-026 Bad words SHALL still be acknowledged, are never pushed, increment ERRCNT (saturating at 2^ERRW-1) and set PERR.
REQ-027 FIFO is first-in first-out; DOUT shows the head whenever DVALID=1.
REQ-028 When DVALID=0, DOUT SHALL hold its last value.
REQ-029 Simultaneous push and pop SHALL leave COUNT unchanged and preserve order.
REQ-030 Pop when empty SHALL be ignored.
REQ-031 Read/write pointers SHALL wrap modulo DEPTH.
REQ-032 A pop while full frees space visible to the IDLE acceptance check on the following cycle.

Reset
REQ-033 HRESET=1 SHALL immediately force: FSM=IDLE, YACK=0, COUNT=0, DVALID=0, DOUT=0, PERR=0, ERRCNT=0, pointers=0.
REQ-034 Reset mid-handshake SHALL drop YACK asynchronously and discard the captured word.
REQ-035 After reset deassertion, a still-high YREQ SHALL be treated as a new request.

Structure
REQ-036 Package y_rx_pkg SHALL hold the state enum, the PARITY_EVEN/PARITY_ODD constants and the default ERRW.
REQ-037 FIFO storage and pointers SHALL live in sub-module y_rx_fifo (push, pop, din, dout, count).
REQ-038 The FSM and parity/error logic SHALL stay in y_receiver.

Verification
REQ-039 Even mode, YDATA=32'h0000_0003, YPARITY=0: YACK=1 one cycle after sample, COUNT=1, DOUT=32'h3, ERRCNT=0.
REQ-040 Odd mode, YDATA=32'h0000_0001, YPARITY=1 (bad): YACK completes handshake, COUNT=0, PERR=1, ERRCNT=1.
REQ-041 DREADY=0, five good words: first four acked and COUNT=4; fifth stalls with YACK=0 until one DREADY pulse, then accepted.
REQ-042 ERRW=8, 300 bad words: ERRCNT saturates at 255 and PERR stays 1.
REQ-043 Assert HRESET while in ACK with COUNT=2: YACK=0 in the same cycle, COUNT=0, DVALID=0; a held YREQ is re-accepted after release.
REQ-044 Push and pop in the same cycle at COUNT=2 over 10 words: COUNT stays 2 and output order matches input order across pointer wrap.
